// File: rtl/tcdm_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank_responder
// Purpose  : Multi-port TCDM slave in front of NB_BANKS word-interleaved
//            32-bit memory banks. Each bank arbitrates its requesting ports
//            with its own round-robin pointer. Every grant gets a response
//            exactly one cycle later. Accesses outside the memory window are
//            granted without touching any bank. They read back 32'hDEAD_BEEF
//            and pulse err_o in the response cycle.
// Ports    : clk_i        - clock, rising edge
//            rst_ni       - asynchronous active-low reset
//            stall_i      - suppresses every grant in the current cycle
//            tcdm_req     - per-port request
//            tcdm_gnt     - per-port grant (combinational)
//            tcdm_add     - per-port byte address
//            tcdm_wen     - per-port 1 = read, 0 = write
//            tcdm_be      - per-port write byte enables
//            tcdm_data    - per-port write data
//            tcdm_r_data  - per-port response data (zero unless read response)
//            tcdm_r_valid - per-port response strobe
//            err_o        - out-of-window access pulse (response cycle)
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_bank_responder #(
  parameter int unsigned MP         = 3,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  output logic                 err_o
);

  localparam int unsigned PW  = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned BW  = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;
  localparam int unsigned BSH = $clog2(NB_BANKS);
  localparam int unsigned RW  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

  // 33-bit bounds so a window ending exactly at 4 GiB still compares correctly
  localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI    = WIN_LO + 33'(4 * NB_BANKS * BANK_WORDS);
  localparam logic [31:0] OOW_RDATA = 32'hDEAD_BEEF;
  localparam logic [PW-1:0] LAST_PORT = PW'(MP - 1);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [29:0]   word_idx  [MP];
  logic [BW-1:0] port_bank [MP];
  logic [RW-1:0] port_row  [MP];
  logic [MP-1:0] in_win;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      word_idx[p]  = 30'((tcdm_add[p] - BASE_ADDR) >> 2);
      in_win[p]    = ({1'b0, tcdm_add[p]} >= WIN_LO) && ({1'b0, tcdm_add[p]} < WIN_HI);
      port_bank[p] = (NB_BANKS > 1) ? word_idx[p][BW-1:0] : '0;
      port_row[p]  = RW'(word_idx[p] >> BSH);
    end
  end

  // --------------------------------------------------------------------------
  // Per-bank round-robin arbitration
  // --------------------------------------------------------------------------
  logic [MP-1:0] bank_req [NB_BANKS];
  logic [PW-1:0] rr_q     [NB_BANKS];
  logic [PW-1:0] rr_d     [NB_BANKS];
  logic [PW-1:0] win_idx  [NB_BANKS];
  logic [NB_BANKS-1:0] win_vld;

  always_comb begin
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int p = 0; p < MP; p++) begin
        bank_req[b][p] = tcdm_req[p] && in_win[p] && (port_bank[p] == BW'(b));
      end
    end
  end

  // Scan ports starting at the pointer, wrapping modulo MP; the first
  // requester found wins. MP need not be a power of two, so wrap explicitly.
  always_comb begin : arb_scan
    logic [PW-1:0] idx;
    for (int b = 0; b < NB_BANKS; b++) begin
      win_vld[b] = 1'b0;
      win_idx[b] = rr_q[b];
      idx        = rr_q[b];
      for (int i = 0; i < MP; i++) begin
        if (!win_vld[b] && bank_req[b][idx]) begin
          win_vld[b] = 1'b1;
          win_idx[b] = idx;
        end
        idx = (idx == LAST_PORT) ? '0 : idx + PW'(1);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NB_BANKS; b++) begin
      rr_d[b] = rr_q[b];
      if (!stall_i && win_vld[b]) begin
        rr_d[b] = (win_idx[b] == LAST_PORT) ? '0 : win_idx[b] + PW'(1);
      end
    end
  end

  // Out-of-window requests bypass the banks and are granted unless stalled.
  always_comb begin
    tcdm_gnt = '0;
    for (int p = 0; p < MP; p++) begin
      if (!stall_i && tcdm_req[p]) begin
        if (!in_win[p]) begin
          tcdm_gnt[p] = 1'b1;
        end else if (win_vld[port_bank[p]] && (win_idx[port_bank[p]] == PW'(p))) begin
          tcdm_gnt[p] = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bank storage: one access (the bank winner) per bank per cycle
  // --------------------------------------------------------------------------
  logic [NB_BANKS-1:0]       acc_we;
  logic [RW-1:0]             acc_row   [NB_BANKS];
  logic [NB_BANKS-1:0][3:0]  acc_be;
  logic [NB_BANKS-1:0][31:0] acc_wdata;
  logic [NB_BANKS-1:0][31:0] bank_rdata;

  always_comb begin
    for (int b = 0; b < NB_BANKS; b++) begin
      acc_we[b]    = !stall_i && win_vld[b] && !tcdm_wen[win_idx[b]];
      acc_row[b]   = port_row[win_idx[b]];
      acc_be[b]    = tcdm_be[win_idx[b]];
      acc_wdata[b] = tcdm_data[win_idx[b]];
    end
  end

  for (genvar gb = 0; gb < NB_BANKS; gb++) begin : g_bank
    logic [31:0] mem [BANK_WORDS];

    // Read is taken from the array before the edge, so a read and a write
    // landing on the same edge return the old word.
    assign bank_rdata[gb] = mem[acc_row[gb]];

    always_ff @(posedge clk_i) begin
      if (acc_we[gb]) begin
        for (int k = 0; k < 4; k++) begin
          if (acc_be[gb][k]) begin
            mem[acc_row[gb]][8*k +: 8] <= acc_wdata[gb][8*k +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  logic [MP-1:0]        r_valid_q, r_valid_d;
  logic [MP-1:0][31:0]  r_data_q,  r_data_d;
  logic                 err_q,     err_d;

  always_comb begin
    r_valid_d = tcdm_gnt;
    err_d     = |(tcdm_gnt & ~in_win);
    for (int p = 0; p < MP; p++) begin
      r_data_d[p] = '0;
      if (tcdm_gnt[p] && tcdm_wen[p]) begin
        r_data_d[p] = in_win[p] ? bank_rdata[port_bank[p]] : OOW_RDATA;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
      err_q     <= 1'b0;
      for (int b = 0; b < NB_BANKS; b++) begin
        rr_q[b] <= '0;
      end
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      err_q     <= err_d;
      for (int b = 0; b < NB_BANKS; b++) begin
        rr_q[b] <= rr_d[b];
      end
    end
  end

  assign tcdm_r_valid = r_valid_q;
  assign tcdm_r_data  = r_data_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_bank_responder
// Purpose  : Self-checking bench for tcdm_bank_responder. A reference model
//            (flat word memory, per-bank pointers) predicts grants and pushes
//            expected responses into a scoreboard queue tagged with the cycle
//            they must appear in; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_responder;

  localparam int          MP     = 3;
  localparam int          NB     = 4;
  localparam int          BWORDS = 256;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam longint      WIN    = 4 * NB * BWORDS;

  logic                clk_i   = 1'b0;
  logic                rst_ni  = 1'b0;
  logic                stall_i = 1'b0;
  logic [MP-1:0]       tcdm_req  = '0;
  logic [MP-1:0]       tcdm_gnt;
  logic [MP-1:0][31:0] tcdm_add  = '0;
  logic [MP-1:0]       tcdm_wen  = '0;
  logic [MP-1:0][3:0]  tcdm_be   = '0;
  logic [MP-1:0][31:0] tcdm_data = '0;
  logic [MP-1:0][31:0] tcdm_r_data;
  logic [MP-1:0]       tcdm_r_valid;
  logic                err_o;

  always #5 clk_i = ~clk_i;

  tcdm_bank_responder #(
    .MP(MP), .NB_BANKS(NB), .BANK_WORDS(BWORDS), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
    .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid), .err_o(err_o)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [31:0]   mem_m [int];
  int            rr_m  [NB];
  bit [MP-1:0]   exp_gnt = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    return (la >= lb) && (la < lb + WIN);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Reference model for one cycle: decide grants from the arbitration rules,
  // queue the responses (reads see memory before this cycle's writes), then
  // apply writes.
  task automatic model_step();
    bit [MP-1:0] g = '0;
    exp_t        e;
    if (!stall_i) begin
      for (int p = 0; p < MP; p++)
        if (tcdm_req[p] && !in_win(tcdm_add[p])) g[p] = 1'b1;
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < MP; k++) begin
          int p;
          p = (rr_m[b] + k) % MP;
          if (tcdm_req[p] && in_win(tcdm_add[p]) && (word_of(tcdm_add[p]) % NB == b)) begin
            g[p]    = 1'b1;
            rr_m[b] = (p + 1) % MP;
            break;
          end
        end
      end
    end
    for (int p = 0; p < MP; p++)
      check($sformatf("gnt[%0d]", p), 32'(tcdm_gnt[p]), 32'(g[p]));
    exp_gnt = g;
    for (int p = 0; p < MP; p++) begin
      if (g[p]) begin
        e.cyc  = cyc + 1;
        e.port = p;
        e.err  = !in_win(tcdm_add[p]);
        e.data = 32'h0;
        if (tcdm_wen[p]) begin
          if (!in_win(tcdm_add[p])) e.data = 32'hDEAD_BEEF;
          else if (mem_m.exists(word_of(tcdm_add[p]))) e.data = mem_m[word_of(tcdm_add[p])];
        end
        sb_q.push_back(e);
      end
    end
    for (int p = 0; p < MP; p++) begin
      if (g[p] && !tcdm_wen[p] && in_win(tcdm_add[p])) begin
        int          w;
        logic [31:0] v;
        w = word_of(tcdm_add[p]);
        v = mem_m.exists(w) ? mem_m[w] : 32'h0;
        for (int k = 0; k < 4; k++)
          if (tcdm_be[p][k]) v[8*k +: 8] = tcdm_data[p][8*k +: 8];
        mem_m[w] = v;
      end
    end
  endtask

  // Monitor: everything expected for this cycle must show up, nothing else.
  always @(negedge clk_i) begin : monitor
    logic [MP-1:0] ev;
    logic [31:0]   ed [MP];
    bit            eerr;
    if (rst_ni) begin
      ev   = '0;
      eerr = 1'b0;
      for (int p = 0; p < MP; p++) ed[p] = 32'h0;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        mon_e = sb_q.pop_front();
        ev[mon_e.port] = 1'b1;
        ed[mon_e.port] = mon_e.data;
        eerr           = eerr | mon_e.err;
      end
      for (int p = 0; p < MP; p++) begin
        check($sformatf("r_valid[%0d]", p), 32'(tcdm_r_valid[p]), 32'(ev[p]));
        check($sformatf("r_data[%0d]", p), tcdm_r_data[p], ed[p]);
      end
      check("err_o", 32'(err_o), 32'(eerr));
    end
  end

  // Called a little after a rising edge; returns a little after the next one.
  task automatic do_cycle();
    @(negedge clk_i);
    #1;
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_ni   = 1'b0;
    tcdm_req = '0;
    stall_i  = 1'b0;
    sb_q.delete();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    #1;
    check("rst_r_valid", 32'(tcdm_r_valid), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    repeat (n) @(posedge clk_i);
    #1;
    check("rst_r_data", tcdm_r_data[0] | tcdm_r_data[1] | tcdm_r_data[2], 32'h0);
    check("rst_r_valid_hold", 32'(tcdm_r_valid), 32'h0);
    rst_ni = 1'b1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic [31:0] a,
                          input logic wen, input logic [3:0] be, input logic [31:0] d);
    tcdm_req[p]  = rq;
    tcdm_add[p]  = a;
    tcdm_wen[p]  = wen;
    tcdm_be[p]   = be;
    tcdm_data[p] = d;
  endtask

  // Addresses limited to initialised words, the window edges and some
  // out-of-window spots; low bits randomised since they must be ignored.
  function automatic logic [31:0] rand_addr();
    int          k;
    logic [31:0] lo;
    k  = $urandom_range(0, 39);
    lo = 32'($urandom_range(0, 3));
    if (k < 32) return BASE + 32'(4 * k) + lo;
    if (k < 36) return BASE + 32'(4 * (1020 + k - 32)) + lo;
    if (k == 36) return BASE - 32'd4;
    if (k == 37) return BASE + 32'(WIN);
    if (k == 38) return 32'h0;
    return BASE + 32'(WIN) + 32'h100;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin : stimulus
    @(posedge clk_i);
    #1;
    apply_reset(2);

    // Write then read back the same word on port 0
    set_port(0, 1'b1, BASE, 1'b0, 4'hF, 32'hCAFE_F00D);
    do_cycle();
    check("wr_resp_valid", 32'(tcdm_r_valid[0]), 32'h1);
    check("wr_resp_data", tcdm_r_data[0], 32'h0);
    set_port(0, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
    do_cycle();
    check("rd_back_data", tcdm_r_data[0], 32'hCAFE_F00D);

    // Initialise the words the random phase may touch
    for (int w = 0; w < 36; w++) begin
      int wi;
      wi = (w < 32) ? w : (1020 + w - 32);
      set_port(0, 1'b1, BASE + 32'(4 * wi), 1'b0, 4'hF, $urandom);
      do_cycle();
    end

    // Partial byte-enable write
    set_port(0, 1'b1, BASE + 32'h10, 1'b0, 4'hF, 32'h1122_3344);
    do_cycle();
    set_port(0, 1'b1, BASE + 32'h10, 1'b0, 4'b0101, 32'hAABB_CCDD);
    do_cycle();
    set_port(0, 1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
    do_cycle();
    check("be_merge", tcdm_r_data[0], 32'h11BB_33DD);

    // Three ports on three different banks in one cycle
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'(4 * p), 1'b1, 4'h0, 32'h0);
    do_cycle();
    check("parallel_valid", 32'(tcdm_r_valid), 32'h7);

    // Out-of-window read
    tcdm_req = '0;
    set_port(1, 1'b1, BASE - 32'd4, 1'b1, 4'h0, 32'h0);
    do_cycle();
    check("oow_data", tcdm_r_data[1], 32'hDEAD_BEEF);
    check("oow_err", 32'(err_o), 32'h1);
    tcdm_req = '0;
    do_cycle();
    check("oow_err_pulse", 32'(err_o), 32'h0);

    // Stall with requests pending
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'(4 * p), 1'b1, 4'h0, 32'h0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_gnt", 32'(tcdm_gnt), 32'h0);
      do_cycle();
    end
    stall_i = 1'b0;
    do_cycle();

    // Reset right after a grant: that response is dropped
    tcdm_req = '0;
    set_port(0, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
    do_cycle();
    apply_reset(2);

    // All ports hammer bank 0: rotation from the reset pointer
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_seq", 32'(tcdm_gnt), 32'(1 << (i % 3)));
      do_cycle();
    end

    // Randomised traffic; ungranted requests are held unchanged
    tcdm_req = '0;
    exp_gnt  = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < MP; p++) begin
        if (!tcdm_req[p] || exp_gnt[p]) begin
          set_port(p, ($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 1)),
                   4'($urandom), $urandom);
        end
      end
      stall_i = ($urandom_range(0, 9) == 0);
      do_cycle();
    end

    tcdm_req = '0;
    stall_i  = 1'b0;
    do_cycle();
    do_cycle();
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
